// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode: circular buffer of
// (pc, instruction) pairs with valid/ready on both sides, first-word fall-through and flush.
module if_prefetch_queue #(
  parameter int ADDRESS_LEN = 32,
  parameter int DEPTH       = 4,
  parameter int COUNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_valid,
  input  logic [ADDRESS_LEN-1:0] push_pc,
  input  logic [ADDRESS_LEN-1:0] push_instruction,
  output logic                   push_ready,
  input  logic                   pop_ready,
  output logic                   pop_valid,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic [ADDRESS_LEN-1:0] instruction_out,
  output logic [COUNT_W-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [COUNT_W-1:0]     count_reg;
  logic [COUNT_W-1:0]     count_next;
  logic [ADDRESS_LEN-1:0] pc_mem    [DEPTH];
  logic [ADDRESS_LEN-1:0] instr_mem [DEPTH];

  logic push_fire;
  logic pop_fire;
  logic empty;

  assign empty      = (count_reg == '0);
  // push_ready looks only at registered occupancy, never at pop_ready.
  assign push_ready = (count_reg != COUNT_W'(DEPTH));
  assign pop_valid  = !empty && !flush;
  assign push_fire  = push_valid && push_ready && !flush;
  assign pop_fire   = pop_valid && pop_ready;

  // Empty queue presents a zero (NOP) bubble rather than stale storage.
  assign pc_out          = empty ? '0 : pc_mem[rd_ptr_reg];
  assign instruction_out = empty ? '0 : instr_mem[rd_ptr_reg];
  assign count           = count_reg;

  always_comb begin
    count_next = count_reg;
    if (push_fire && !pop_fire) begin
      count_next = count_reg + COUNT_W'(1);
    end else if (pop_fire && !push_fire) begin
      count_next = count_reg - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Storage is not cleared on flush; the zeroed pointers make old entries unreachable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push_fire) begin
      pc_mem[wr_ptr_reg]    <= push_pc;
      instr_mem[wr_ptr_reg] <= push_instruction;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios then random traffic, checked
// against a queue-based reference model of FIFO occupancy and ordering.
module tb_if_prefetch_queue;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          push_valid;
  logic [AW-1:0] push_pc;
  logic [AW-1:0] push_instruction;
  logic          push_ready;
  logic          pop_ready;
  logic          pop_valid;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] instruction_out;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] ins;
  } ent_t;

  ent_t model_q[$];

  if_prefetch_queue #(.ADDRESS_LEN(AW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push_valid(push_valid),
    .push_pc(push_pc),
    .push_instruction(push_instruction),
    .push_ready(push_ready),
    .pop_ready(pop_ready),
    .pop_valid(pop_valid),
    .pc_out(pc_out),
    .instruction_out(instruction_out),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the model says the queue should show.
  task automatic check_outputs(input string tag, input logic fl);
    int n;
    n = model_q.size();
    chk({tag, ".count"},      32'(count),      32'(n));
    chk({tag, ".push_ready"}, 32'(push_ready), 32'(n != DEPTH));
    chk({tag, ".pop_valid"},  32'(pop_valid),  32'((n != 0) && !fl));
    chk({tag, ".pc_out"},     pc_out,          (n != 0) ? model_q[0].pc  : 32'h0);
    chk({tag, ".instr_out"},  instruction_out, (n != 0) ? model_q[0].ins : 32'h0);
  endtask

  // Called just after a rising edge: drive, check before next edge, update model on it.
  task automatic do_cycle(input string tag, input logic pv, input logic [AW-1:0] pc,
                          input logic [AW-1:0] ins, input logic pr, input logic fl);
    bit push_ok, pop_ok;
    ent_t e;
    push_valid = pv; push_pc = pc; push_instruction = ins;
    pop_ready = pr; flush = fl;
    @(negedge clk);
    check_outputs(tag, fl);
    push_ok = pv && (model_q.size() < DEPTH) && !fl;
    pop_ok  = pr && (model_q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop_ok) void'(model_q.pop_front());
      if (push_ok) begin
        e.pc = pc; e.ins = ins;
        model_q.push_back(e);
      end
    end
    #1;
    $display("cycle %s pv=%0b pc=%h pr=%0b fl=%0b -> model_count=%0d", tag, pv, pc, pr, fl, model_q.size());
  endtask

  function automatic logic [AW-1:0] ins_of(input logic [AW-1:0] pc);
    return 32'hA500_0000 ^ (pc * 32'h0001_0001);
  endfunction

  initial begin
    rst = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_pc = '0; push_instruction = '0;

    // Reset state, checked while rst is held low.
    #3;
    check_outputs("reset", 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Fill to full, then a refused fifth push.
    for (int i = 0; i < 4; i++) do_cycle("fill", 1'b1, 32'(i * 4), ins_of(32'(i * 4)), 1'b0, 1'b0);
    do_cycle("full_push", 1'b1, 32'h10, ins_of(32'h10), 1'b0, 1'b0);
    do_cycle("full_hold", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Drain in order, then observe empty.
    for (int i = 0; i < 4; i++) do_cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    do_cycle("empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming push+pop with pointer wrap.
    for (int i = 0; i < 10; i++) do_cycle("stream", 1'b1, 32'(i * 4), ins_of(32'(i * 4)), 1'b1, 1'b0);
    do_cycle("stream_tail", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    do_cycle("stream_end", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with concurrent push and pop; the flushed push must never emerge.
    for (int i = 0; i < 3; i++) do_cycle("pre_flush", 1'b1, 32'h20 + 32'(i * 4), ins_of(32'h20 + 32'(i * 4)), 1'b0, 1'b0);
    do_cycle("flush", 1'b1, 32'h40, ins_of(32'h40), 1'b1, 1'b1);
    do_cycle("post_flush", 1'b1, 32'h80, ins_of(32'h80), 1'b0, 1'b0);
    do_cycle("after_flush", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    do_cycle("flush_empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

    // Full with simultaneous pop: push refused, accepted on the next cycle.
    for (int i = 0; i < 4; i++) do_cycle("refill", 1'b1, 32'h100 + 32'(i * 4), ins_of(32'h100 + 32'(i * 4)), 1'b0, 1'b0);
    do_cycle("full_pop", 1'b1, 32'h110, ins_of(32'h110), 1'b1, 1'b0);
    do_cycle("retry_push", 1'b1, 32'h110, ins_of(32'h110), 1'b0, 1'b0);
    do_cycle("refull", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Async reset between edges with entries queued.
    for (int i = 0; i < 2; i++) do_cycle("flush2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    do_cycle("two_left", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_q.delete();
    check_outputs("async_rst", 1'b0);
    $display("cycle async_rst asserted between edges -> model_count=0");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    do_cycle("resume", 1'b1, 32'h200, ins_of(32'h200), 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] rpc;
      rpc = $urandom;
      do_cycle("rand", ($urandom_range(0, 9) < 7), rpc, $urandom, $urandom_range(0, 1) == 1,
               $urandom_range(0, 19) == 0);
    end
    do_cycle("rand_end", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
